// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// spi_master_if : host-side handshake and SPI pin bundle for spi_master
//                 (err is present only when SPI_MASTER_ERR_EN is defined)
// Revision      : 1.0
// ============================================================================
interface spi_master_if;
   logic       start;
   logic [9:0] cmd_in;
   logic       busy;
   logic       done;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
`ifdef SPI_MASTER_ERR_EN
   logic       err;
`endif

   modport master (
      input  start,
      input  cmd_in,
      input  MISO,
      output busy,
      output done,
      output rx_byte,
      output rx_valid,
      output SS_n,
      output MOSI
`ifdef SPI_MASTER_ERR_EN
      , output err
`endif
   );

   modport slave (
      output start,
      output cmd_in,
      output MISO,
      input  busy,
      input  done,
      input  rx_byte,
      input  rx_valid,
      input  SS_n,
      input  MOSI
`ifdef SPI_MASTER_ERR_EN
      , input err
`endif
   );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// spi_master : 10-bit command SPI master with optional 8-bit read-back;
//              SPI_MASTER_ERR_EN adds an err pulse for starts seen while busy
// Revision   : 1.0
// ============================================================================
module spi_master #(
   parameter int RD_WAIT = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   spi_master_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_SEL   = 4'd1,
      S_CMD   = 4'd2,
      S_SHIFT = 4'd3,
      S_VALID = 4'd4,
      S_WAIT  = 4'd5,
      S_RECV  = 4'd6,
      S_DONE  = 4'd7
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] shadow_q, shadow_d;
   logic [7:0] sr_q, sr_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic       ss_n_q, ss_n_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rx_valid_q, rx_valid_d;
   logic       is_rd_data;

   assign is_rd_data = (shadow_q[9:8] == 2'b11);

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      sr_d      = sr_q;
      rx_byte_d = rx_byte_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_SEL;
               shadow_d = bus.cmd_in;
            end
         end
         S_SEL:   state_d = S_CMD;
         S_CMD:   state_d = S_SHIFT;
         S_SHIFT: begin
            if (cnt_q == 4'd9) state_d = S_VALID;
         end
         S_VALID: begin
            if (!is_rd_data)       state_d = S_DONE;
            else if (RD_WAIT == 0) state_d = S_RECV;
            else                   state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) state_d = S_RECV;
         end
         S_RECV: begin
            sr_d = {sr_q[6:0], bus.MISO};
            if (cnt_q == 4'd7) begin
               state_d   = S_DONE;
               rx_byte_d = sr_d;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Counter restarts on every state change so it always indexes within the state.
      cnt_d = ((state_d == state_q) && (state_q != S_IDLE)) ? cnt_q + 4'd1 : 4'd0;

      // Outputs are registered from the next state so they line up with it.
      ss_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
      mosi_d = 1'b0;
      if (state_d == S_CMD)   mosi_d = shadow_q[9];
      if (state_d == S_SHIFT) mosi_d = shadow_q[4'd9 - cnt_d];
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      rx_valid_d = (state_q == S_RECV) && (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         shadow_q   <= 10'd0;
         sr_q       <= 8'd0;
         rx_byte_q  <= 8'd0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         sr_q       <= sr_d;
         rx_byte_q  <= rx_byte_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign bus.SS_n     = ss_n_q;
   assign bus.MOSI     = mosi_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rx_byte  = rx_byte_q;
   assign bus.rx_valid = rx_valid_q;

`ifdef SPI_MASTER_ERR_EN
   logic err_q, err_d;

   // Flags a start that arrives while a frame (including DONE) is in flight.
   always_comb begin
      err_d = bus.start && (state_q != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign bus.err = err_q;
`endif

endmodule
`default_nettype wire
